// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned RAM_DEPTH  = 128;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_ADDR_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Request payload latched from the winning port.
    typedef struct packed {
        logic                  we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the port not granted last wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Port 0 wins alone or when port 1 was granted last; port 1 symmetric.
    always_comb begin
        gnt[0] = req[0] & (~req[1] | (last == PORT1));
        gnt[1] = req[1] & (~req[0] | (last == PORT0));
        gnt_id = gnt[1] ? PORT1 : PORT0;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin access controller for the 128x8 combinational-read data RAM.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              ill_q, ill_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic              rd_en_d, wr_en_d, ack0_d, ack1_d, err_d, busy_d;

    logic [1:0]        gnt_c;
    logic              gnt_id_c;
    mem_req_t          sel_c;
    logic              sel_ill_c;

    rr_arb2 u_arb (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .gnt    (gnt_c),
        .gnt_id (gnt_id_c)
    );

    // Payload of the winning port and its address legality.
    assign sel_c     = (gnt_id_c == PORT1) ? {m1_we, m1_addr, m1_wdata}
                                           : {m0_we, m0_addr, m0_wdata};
    assign sel_ill_c = (32'(sel_c.addr) >= DEPTH);

    // Next-state and next-output logic; RAM strobes are set one edge ahead so they are high exactly in ACCESS.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        ill_d   = ill_q;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    state_d = ACCESS;
                    last_d  = gnt_id_c;
                    id_d    = gnt_id_c;
                    we_d    = sel_c.we;
                    ill_d   = sel_ill_c;
                    addr_d  = sel_c.addr;
                    wdata_d = sel_c.wdata;
                    rd_en_d = ~sel_c.we & ~sel_ill_c;
                    wr_en_d = sel_c.we & ~sel_ill_c;
                end
            end
            ACCESS: begin
                state_d = RESP;
                ack0_d  = (id_q == PORT0);
                ack1_d  = (id_q == PORT1);
                err_d   = ill_q;
                rdata_d = (~we_q & ~ill_q) ? ram_rdata : '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= PORT1;
            id_q      <= PORT0;
            we_q      <= 1'b0;
            ill_q     <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_rd_en <= 1'b0;
            ram_wr_en <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            we_q      <= we_d;
            ill_q     <= ill_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            ram_rd_en <= rd_en_d;
            ram_wr_en <= wr_en_d;
            m0_ack    <= ack0_d;
            m1_ack    <= ack1_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, hand sequences and a randomized model run.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic       clk, rst_n;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m1_ack, rsp_err, busy, ram_rd_en, ram_wr_en;
    logic [7:0] rsp_rdata, ram_addr, ram_wdata, ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 128 words, low 7 address bits decoded, preloaded with mem[i]=i.
    logic [7:0] mem [0:127];
    logic       mem_load;
    assign ram_rdata = mem[ram_addr[6:0]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
        end else if (ram_wr_en) begin
            mem[ram_addr[6:0]] <= ram_wdata;
        end
    end

    typedef struct {
        int         port;
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } obs_t;

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_wr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one or two requests from a negedge with the DUT idle and watch 8 cycles.
    task automatic txn(input logic r0, input logic r1, input logic we0, input logic we1,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       output obs_t o0, output obs_t o1,
                       output int nack, output int nwr, output int nclash);
        obs_t o;
        nack = 0; nwr = 0; nclash = 0;
        o0 = '{port: -1, rdata: 8'h0, err: 1'b0, cyc: -1};
        o1 = o0;
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_wr_en) nwr++;
            if (ram_wr_en && ram_rd_en) nclash++;
            if (m0_ack && m1_ack) nclash++;
            if (m0_ack || m1_ack) begin
                o.port = m1_ack ? 1 : 0;
                o.rdata = rsp_rdata;
                o.err = rsp_err;
                o.cyc = c;
                if (nack == 0) o0 = o;
                else if (nack == 1) o1 = o;
                nack++;
                if (m0_ack) m0_req = 1'b0;
                if (m1_ack) m1_req = 1'b0;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t       vecs [8];
    obs_t       o0, o1;
    int         nack, nwr, nclash;
    logic [7:0] ref_mem [0:127];
    int         ref_last;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        rst_n = 1'b0;
        mem_load = 1'b1;

        // Reset: all outputs zero after 3 cycles of rst_n low.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({m0_ack, m1_ack, rsp_rdata, rsp_err, busy, ram_addr, ram_wdata, ram_rd_en, ram_wr_en}),
              32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        mem_load = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single-port vectors; expectations hand-derived from mem[i]=i plus earlier writes.
        vecs[0] = '{1'b0, 1'b0, 8'h25, 8'h00, 8'h25, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, 8'h80, 8'h55, 8'h00, 1'b1, 0};
        vecs[4] = '{1'b0, 1'b0, 8'h7F, 8'h00, 8'h7F, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 0};
        vecs[6] = '{1'b0, 1'b1, 8'h7F, 8'h3C, 8'h00, 1'b0, 1};
        vecs[7] = '{1'b1, 1'b0, 8'h7F, 8'h00, 8'h3C, 1'b0, 0};
        for (int i = 0; i < 8; i++) begin
            txn(!vecs[i].port, vecs[i].port, vecs[i].we, vecs[i].we,
                vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].wdata,
                o0, o1, nack, nwr, nclash);
            check($sformatf("vec%0d_nack", i), 32'(nack), 32'd1);
            check($sformatf("vec%0d_port", i), 32'(o0.port), 32'(vecs[i].port));
            check($sformatf("vec%0d_latency", i), 32'(o0.cyc), 32'd2);
            check($sformatf("vec%0d_rdata", i), 32'(o0.rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 32'(o0.err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_wr_pulses", i), 32'(nwr), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_clash", i), 32'(nclash), 32'd0);
            check($sformatf("vec%0d_addr_hold", i), 32'(ram_addr), 32'(vecs[i].addr));
        end
        check("illegal_write_mem0", 32'(mem[0]), 32'h00);
        check("write_landed_0x10", 32'(mem[8'h10]), 32'hA5);

        // Contention: after reset port 0 wins the first tie, loser follows 3 cycles later.
        do_reset();
        txn(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, o0, o1, nack, nwr, nclash);
        check("tie1_nack", 32'(nack), 32'd2);
        check("tie1_first", 32'(o0.port), 32'd0);
        check("tie1_first_rdata", 32'(o0.rdata), 32'h01);
        check("tie1_second", 32'(o1.port), 32'd1);
        check("tie1_second_rdata", 32'(o1.rdata), 32'h02);
        check("tie1_second_cyc", 32'(o1.cyc), 32'd5);
        // A port-0 grant moves the pointer, so port 1 takes the next tie.
        txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, o0, o1, nack, nwr, nclash);
        check("solo_m0_rdata", 32'(o0.rdata), 32'h04);
        txn(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 8'h00, 8'h00, o0, o1, nack, nwr, nclash);
        check("tie2_first", 32'(o0.port), 32'd1);
        check("tie2_first_rdata", 32'(o0.rdata), 32'h06);
        check("tie2_second", 32'(o1.port), 32'd0);
        check("tie2_second_cyc", 32'(o1.cyc), 32'd5);

        // Reset during ACCESS abandons the access with no ack.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h03;
        @(negedge clk);
        check("midrst_in_access", 32'({busy, ram_rd_en}), 32'h3);
        rst_n = 1'b0;
        #1;
        check("midrst_cleared", 32'({busy, ram_rd_en, m0_ack, m1_ack}), 32'h0);
        m0_req = 1'b0;
        nack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) nack++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) nack++;
        end
        check("midrst_no_ack", 32'(nack), 32'd0);
        txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00, o0, o1, nack, nwr, nclash);
        check("midrst_fresh_rdata", 32'(o0.rdata), 32'h03);
        check("midrst_fresh_latency", 32'(o0.cyc), 32'd2);

        // Randomized run against a transaction-level model: served order, memory contents.
        do_reset();
        ref_last = 1;
        for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
        for (int r = 0; r < 40; r++) begin
            logic [1:0] sel;
            logic       we [2];
            logic [7:0] ad [2];
            logic [7:0] wd [2];
            int         order [2];
            int         n;
            logic [7:0] e_rd [2];
            logic       e_er [2];
            int         e_wr;
            sel = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                we[p] = 1'($urandom);
                if ($urandom % 8 == 0) ad[p] = 8'(128 + $urandom % 128);
                else ad[p] = 8'($urandom % 16);
                wd[p] = 8'($urandom);
            end
            if (sel == 2'b11) begin
                n = 2;
                order[0] = (ref_last == 1) ? 0 : 1;
                order[1] = 1 - order[0];
            end else begin
                n = 1;
                order[0] = sel[1] ? 1 : 0;
                order[1] = -1;
            end
            e_wr = 0;
            for (int k = 0; k < n; k++) begin
                int p;
                p = order[k];
                if (ad[p] >= 8'd128) begin
                    e_rd[k] = 8'h00; e_er[k] = 1'b1;
                end else if (we[p]) begin
                    e_rd[k] = 8'h00; e_er[k] = 1'b0;
                    ref_mem[ad[p][6:0]] = wd[p];
                    e_wr++;
                end else begin
                    e_rd[k] = ref_mem[ad[p][6:0]]; e_er[k] = 1'b0;
                end
            end
            ref_last = order[n-1];

            txn(sel[0], sel[1], we[0], we[1], ad[0], ad[1], wd[0], wd[1],
                o0, o1, nack, nwr, nclash);
            check($sformatf("rnd%0d_nack", r), 32'(nack), 32'(n));
            check($sformatf("rnd%0d_port0", r), 32'(o0.port), 32'(order[0]));
            check($sformatf("rnd%0d_rdata0", r), 32'(o0.rdata), 32'(e_rd[0]));
            check($sformatf("rnd%0d_err0", r), 32'(o0.err), 32'(e_er[0]));
            check($sformatf("rnd%0d_cyc0", r), 32'(o0.cyc), 32'd2);
            if (n == 2) begin
                check($sformatf("rnd%0d_port1", r), 32'(o1.port), 32'(order[1]));
                check($sformatf("rnd%0d_rdata1", r), 32'(o1.rdata), 32'(e_rd[1]));
                check($sformatf("rnd%0d_err1", r), 32'(o1.err), 32'(e_er[1]));
                check($sformatf("rnd%0d_cyc1", r), 32'(o1.cyc), 32'd5);
            end
            check($sformatf("rnd%0d_wr_pulses", r), 32'(nwr), 32'(e_wr));
            check($sformatf("rnd%0d_clash", r), 32'(nclash), 32'd0);
        end
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
            check("rnd_final_mem_mismatch_words", 32'(bad), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
